// File: rtl/core_sequencer_if.sv
// Memory handshake bundle between the control sequencer and the
// instruction/data memory ports. The sequencer is the master: it raises the
// requests and the memories answer with ready.
interface core_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic ir_en;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output ir_en,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  ir_en,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the RV32I core.
// Walks every instruction through FETCH, DECODE, EXEC, (MEM), WB and routes
// illegal/ecall/bus-timeout events through a one-cycle TRAP state. An ebreak
// parks the core in HALT until a debug resume, after which the instruction
// retires through WB like any other.
// All enables are decoded from the registered state, so pulling rst_n low
// drops every request and write strobe immediately.
module core_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    core_sequencer_if.master bus,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             branch,
    input  logic             jump,
    input  logic             csr_write,
    input  logic             is_ecall,
    input  logic             is_ebreak,
    input  logic             illegal,
    input  logic             branch_taken,
    input  logic             resume,
    output logic             rf_we,
    output logic             csr_we,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             trap_enter,
    output logic [1:0]       trap_cause,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP,
        S_HALT
    } state_t;

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b00;
    localparam logic [1:0] CAUSE_ECALL    = 2'b01;
    localparam logic [1:0] CAUSE_FETCH_TO = 2'b10;
    localparam logic [1:0] CAUSE_DATA_TO  = 2'b11;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_TRAP   = 2'b10;

    state_t            state_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic [1:0]        cause_reg;
    logic [CNT_W-1:0]  instret_reg;
    logic              to_expired;
    logic              take_target;

    // A zero TIMEOUT never expires, so the core waits on ready forever.
    assign to_expired  = (TIMEOUT != 0) && (to_cnt_reg == TO_LAST);
    assign take_target = jump | (branch & branch_taken);

    // Sequencer state, wait counter, trap cause and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_RESET;
            to_cnt_reg  <= '0;
            cause_reg   <= CAUSE_ILLEGAL;
            instret_reg <= '0;
        end else begin
            case (state_reg)
                S_RESET: begin
                    state_reg  <= S_FETCH;
                    to_cnt_reg <= '0;
                end
                S_FETCH: begin
                    // Ready on the last allowed cycle still wins over the trap.
                    if (bus.imem_ready) begin
                        state_reg <= S_DECODE;
                    end else if (to_expired) begin
                        state_reg <= S_TRAP;
                        cause_reg <= CAUSE_FETCH_TO;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
                end
                S_DECODE: begin
                    if (illegal) begin
                        state_reg <= S_TRAP;
                        cause_reg <= CAUSE_ILLEGAL;
                    end else if (is_ecall) begin
                        state_reg <= S_TRAP;
                        cause_reg <= CAUSE_ECALL;
                    end else if (is_ebreak) begin
                        state_reg <= S_HALT;
                    end else begin
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (mem_read | mem_write) begin
                        state_reg  <= S_MEM;
                        to_cnt_reg <= '0;
                    end else begin
                        state_reg <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        state_reg <= S_WB;
                    end else if (to_expired) begin
                        state_reg <= S_TRAP;
                        cause_reg <= CAUSE_DATA_TO;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
                end
                S_WB: begin
                    state_reg   <= S_FETCH;
                    to_cnt_reg  <= '0;
                    instret_reg <= instret_reg + CNT_W'(1);
                end
                S_TRAP: begin
                    state_reg  <= S_FETCH;
                    to_cnt_reg <= '0;
                end
                S_HALT: begin
                    if (resume) begin
                        state_reg <= S_WB;
                    end
                end
                default: begin
                    state_reg <= S_RESET;
                end
            endcase
        end
    end

    // Moore output decode of the current state; ir_en alone follows imem_ready.
    always_comb begin
        bus.imem_req = 1'b0;
        bus.ir_en    = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        rf_we        = 1'b0;
        csr_we       = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = PC_PLUS4;
        trap_enter   = 1'b0;
        halted       = 1'b0;
        case (state_reg)
            S_FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_en    = bus.imem_ready;
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = mem_write;
            end
            S_WB: begin
                rf_we  = reg_write;
                csr_we = csr_write;
                pc_en  = 1'b1;
                pc_sel = take_target ? PC_TARGET : PC_PLUS4;
            end
            S_TRAP: begin
                trap_enter = 1'b1;
                pc_en      = 1'b1;
                pc_sel     = PC_TRAP;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign trap_cause = cause_reg;
    assign instret    = instret_reg;

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback. It consumes the per-instruction control bits produced by the main decoder, plus the memory handshakes. It produces the register-file, CSR, PC and memory enables, handles ecall, illegal-instruction and bus-timeout traps, and parks the core on ebreak until a debug resume.

## Interface
- `TIMEOUT`, default 16: max wait cycles for imem/dmem ready; 0 disables the timeout.
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; one clock; asynchronous, active-low.
- `imem_ready`  in  1  instruction word valid this cycle.
- `dmem_ready`  in  1  data access complete this cycle.
- `reg_write, mem_read, mem_write, branch, jump, csr_write, is_ecall, is_ebreak`  in  1 each  decoded control of the instruction in IR.
- `illegal`  in  1  decoded instruction is illegal.
- `branch_taken`  in  1  ALU compare result, valid in WB.
- `resume`  in  1  debug resume request.
- `imem_req`  out  1  instruction fetch request.
- `ir_en`  out  1  latch instruction register.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  data access is a store.
- `rf_we`  out  1  register-file write.
- `csr_we`  out  1  CSR write.
- `pc_en`  out  1  PC update.
- `pc_sel`  out  2  next PC source: 00 = PC+4, 01 = branch/jump target, 10 = trap vector.
- `trap_enter`  out  1  trap taken this cycle.
- `trap_cause`  out  2  cause of the last trap: 00 = illegal, 01 = ecall, 10 = fetch timeout, 11 = data timeout.
- `halted`  out  1  core parked on ebreak.
- `instret`  out  CNT_W  retired-instruction count.

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, TRAP, HALT.
- Outputs are Moore-decoded from the registered state, except `ir_en`, which is `imem_ready` gated by FETCH.
- Outputs not asserted by a state are 0.
- **RESET:** all outputs 0. Goes to FETCH next cycle unconditionally.
- **FETCH:** `imem_req` = 1.
  - `imem_ready` → `ir_en` = 1 this cycle, go to DECODE.
  - Timeout → TRAP with cause 10.
- **DECODE:** one cycle. Priority: `illegal` → TRAP (cause 00); else `is_ecall` → TRAP (cause 01); else `is_ebreak` → HALT; else EXEC.
- **EXEC:** one cycle. `mem_read | mem_write` → MEM; else WB.
- **MEM:** `dmem_req` = 1, `dmem_we` = `mem_write`.
  - `dmem_ready` → WB.
  - Timeout → TRAP with cause 11.
- **WB:** one cycle.
  - `rf_we` = `reg_write`, `csr_we` = `csr_write`, `pc_en` = 1.
  - `pc_sel` = 01 if `jump | (branch & branch_taken)`, else 00.
  - `instret` += 1 (wraps modulo 2^CNT_W). Go to FETCH.
- **TRAP:** one cycle. `trap_enter` = 1, `pc_en` = 1, `pc_sel` = 10. `trap_cause` is registered on entry. No `rf_we`, no `instret` increment. Go to FETCH.
- **HALT:** `halted` = 1, all enables 0. `resume` → WB. `reg_write` is 0 for ebreak, so only the PC advances and `instret` increments.
- **Timeout counter:** cleared on entry to FETCH and to MEM; increments each cycle in that state while ready is low.
  - When the counter reaches `TIMEOUT`-1 with ready low, the next state is TRAP.
  - Ready on that same cycle wins: normal transition, no trap.
  - `TIMEOUT` = 0: waits indefinitely.
- Decoded inputs must be stable from DECODE through WB; IR is not reloaded until the next FETCH.

## Timing
- Reset values: state RESET; all outputs 0; `trap_cause` = 00; `instret` = 0; timeout counter 0.
- Asserting `rst_n` low mid-instruction drops every request and enable asynchronously. No partial writeback.
- Minimum latency, ready returned in the same cycle as the request:
  - ALU/branch/jump: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Each cycle of ready-low wait adds one.
- The request is held high continuously until ready; no retraction.
- `resume` is ignored outside HALT.
- `instret` is registered and visible the cycle after WB.

## Test plan
- ADD with `imem_ready` immediate after reset release → states RESET, FETCH, DECODE, EXEC, WB; `rf_we` = 1 in cycle 4 only; `pc_sel` = 00; `instret` = 1.
- LW with `dmem_ready` delayed 3 cycles → `dmem_req` high 4 cycles, `dmem_we` = 0, `rf_we` in the following WB; total 8 cycles.
- BEQ with `branch_taken` = 1, then = 0 → WB `pc_sel` = 01, then 00; `rf_we` = 0 both times.
- `TIMEOUT` = 4, `imem_ready` never asserted → `imem_req` high 4 cycles, then TRAP: `trap_enter` = 1, `pc_sel` = 10, `trap_cause` = 10, `instret` unchanged. Repeat with ready on the 4th cycle → no trap.
- ecall, then illegal with ecall also set → `trap_cause` = 01, then 00 (illegal has priority).
- ebreak → `halted` = 1 held 10 cycles, `resume` pulse → WB with `pc_sel` = 00, `instret` +1. Also assert `rst_n` low mid-MEM → `dmem_req` drops to 0 immediately.
